// File: rtl/ili_window_writer.sv
// Window-setup + pixel byte streamer for the ILI9341 SPI path.
// Emits CASET/PASET/RAMWR with parameters, then RGB565 pixels as hi/lo byte pairs.
module ili_window_writer #(
    parameter int H_RES = 240,
    parameter int V_RES = 320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [8:0]  i_x0,
    input  logic [8:0]  i_x1,
    input  logic [8:0]  i_y0,
    input  logic [8:0]  i_y1,
    input  logic        i_pix_valid,
    input  logic [15:0] i_pix_data,
    output logic        o_pix_ready,
    output logic        o_byte_valid,
    output logic [7:0]  o_byte,
    output logic        o_dc,
    input  logic        i_byte_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [3:0] {
        IDLE, CASET_C, CASET_P, PASET_C, PASET_P, RAMWR_C,
        PIX_WAIT, PIX_HI, PIX_LO, DONE
    } state_t;

    localparam logic [9:0] H_LIM = 10'(H_RES);
    localparam logic [9:0] V_LIM = 10'(V_RES);

    state_t      state, state_nx;
    logic [8:0]  x0_q, x1_q, y0_q, y1_q;
    logic [1:0]  idx;
    logic [16:0] cnt;
    logic [15:0] pix_q;
    logic        err_q;
    logic        byte_hs;
    logic        win_ok;
    logic [8:0]  prm_lo, prm_hi;
    logic [7:0]  prm_byte;
    logic [9:0]  win_w, win_h;
    logic [19:0] area;

    assign win_ok = (i_x0 <= i_x1) && ({1'b0, i_x1} < H_LIM) &&
                    (i_y0 <= i_y1) && ({1'b0, i_y1} < V_LIM);

    assign byte_hs = o_byte_valid & i_byte_ready;
    assign o_busy  = (state != IDLE);
    assign o_err   = err_q;

    // Both parameter phases share the same 4-byte layout: start hi/lo, end hi/lo.
    assign prm_lo = (state == CASET_P) ? x0_q : y0_q;
    assign prm_hi = (state == CASET_P) ? x1_q : y1_q;
    always_comb begin
        case (idx)
            2'd0:    prm_byte = {7'b0, prm_lo[8]};
            2'd1:    prm_byte = prm_lo[7:0];
            2'd2:    prm_byte = {7'b0, prm_hi[8]};
            default: prm_byte = prm_hi[7:0];
        endcase
    end

    assign win_w = {1'b0, x1_q} - {1'b0, x0_q} + 10'd1;
    assign win_h = {1'b0, y1_q} - {1'b0, y0_q} + 10'd1;
    assign area  = win_w * win_h;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        o_byte_valid = 1'b0;
        o_byte       = 8'h00;
        o_dc         = 1'b0;
        o_pix_ready  = 1'b0;
        o_done       = 1'b0;
        case (state)
            IDLE: if (i_start && win_ok) state_nx = CASET_C;
            CASET_C: begin
                o_byte_valid = 1'b1;
                o_byte       = 8'h2A;
                if (byte_hs) state_nx = CASET_P;
            end
            CASET_P: begin
                o_byte_valid = 1'b1;
                o_dc         = 1'b1;
                o_byte       = prm_byte;
                if (byte_hs && idx == 2'd3) state_nx = PASET_C;
            end
            PASET_C: begin
                o_byte_valid = 1'b1;
                o_byte       = 8'h2B;
                if (byte_hs) state_nx = PASET_P;
            end
            PASET_P: begin
                o_byte_valid = 1'b1;
                o_dc         = 1'b1;
                o_byte       = prm_byte;
                if (byte_hs && idx == 2'd3) state_nx = RAMWR_C;
            end
            RAMWR_C: begin
                o_byte_valid = 1'b1;
                o_byte       = 8'h2C;
                if (byte_hs) state_nx = PIX_WAIT;
            end
            PIX_WAIT: begin
                o_pix_ready = 1'b1;
                if (i_pix_valid) state_nx = PIX_HI;
            end
            PIX_HI: begin
                o_byte_valid = 1'b1;
                o_dc         = 1'b1;
                o_byte       = pix_q[15:8];
                if (byte_hs) state_nx = PIX_LO;
            end
            PIX_LO: begin
                o_byte_valid = 1'b1;
                o_dc         = 1'b1;
                o_byte       = pix_q[7:0];
                if (byte_hs) state_nx = (cnt == 17'd1) ? DONE : PIX_WAIT;
            end
            DONE: begin
                o_done   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q  <= '0;
            x1_q  <= '0;
            y0_q  <= '0;
            y1_q  <= '0;
            idx   <= '0;
            cnt   <= '0;
            pix_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && i_start && !win_ok;
            if (state == IDLE && i_start) begin
                x0_q <= i_x0;
                x1_q <= i_x1;
                y0_q <= i_y0;
                y1_q <= i_y1;
            end
            // idx wraps back to 0 on the last parameter, ready for the next phase
            if (byte_hs && (state == CASET_P || state == PASET_P))
                idx <= idx + 2'd1;
            if (byte_hs && state == RAMWR_C)
                cnt <= area[16:0];
            if (state == PIX_WAIT && i_pix_valid)
                pix_q <= i_pix_data;
            if (byte_hs && state == PIX_LO)
                cnt <= cnt - 17'd1;
        end
    end

endmodule
